// File: rtl/alvio_pkg.sv
// Shared types and constants for the commit-side violation scanner.
// Optional stats counters are enabled with ALVIO_STATS_EN.
package alvio_pkg;
    localparam int AL_INDEX     = 7;
    localparam int VIO_LOAD_BIT = 0;
    localparam int VIO_EXC_BIT  = 1;

    typedef logic [AL_INDEX-1:0] al_idx_t;

    typedef enum logic [1:0] {
        RUN,
        REQ,
        DRAIN
    } scan_state_e;
endpackage

// File: rtl/alvio_commit_scan_prefix_grant.sv
// Contiguous-prefix AND chain: a lane is granted only if it and every
// older lane are clean.
module alvio_prefix_grant #(
    parameter int COMMIT_W = 4
) (
    input  logic [COMMIT_W-1:0] i_clean,
    output logic [COMMIT_W-1:0] o_grant
);
    logic w_run;

    always_comb begin
        w_run   = 1'b1;
        o_grant = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            w_run      = w_run & i_clean[i];
            o_grant[i] = w_run;
        end
    end
endmodule

// File: rtl/alvio_commit_scan.sv
// Commit-side reader of the active-list violation RAM with recovery FSM.
// Define ALVIO_STATS_EN to add saturating load-violation/exception counters.
module alvio_commit_scan
    import alvio_pkg::*;
#(
    parameter int COMMIT_W = 4,
    parameter int DEPTH    = 128,
    parameter int INDEX    = 7,
    parameter int WIDTH    = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [INDEX-1:0]          alHead_i,
    input  logic [COMMIT_W-1:0]       commitReady_i,
    output logic [COMMIT_W*INDEX-1:0] rdAddr_o,
    input  logic [COMMIT_W*WIDTH-1:0] rdData_i,
    output logic [COMMIT_W-1:0]       commitValid_o,
    output logic                      recoverReq_o,
    output logic [INDEX-1:0]          recoverIdx_o,
    output logic [WIDTH-1:0]          recoverCause_o,
    input  logic                      recoverAck_i,
    input  logic                      flushDone_i,
    output logic                      busy_o
`ifdef ALVIO_STATS_EN
    ,
    output logic [31:0]               loadVioCnt_o,
    output logic [31:0]               excCnt_o
`endif
);
    scan_state_e         r_state;
    logic                r_req;
    logic [INDEX-1:0]    r_idx;
    logic [WIDTH-1:0]    r_cause;
    logic [COMMIT_W-1:0] w_clean;
    logic [COMMIT_W-1:0] w_grant;
    logic [WIDTH-1:0]    w_lane0;
    logic                w_detect;

    always_comb begin
        for (int i = 0; i < COMMIT_W; i++) begin
            rdAddr_o[i*INDEX +: INDEX] =
                INDEX'((int'(alHead_i) + i) % DEPTH);
            w_clean[i] = commitReady_i[i] &
                (rdData_i[i*WIDTH +: WIDTH] == '0);
        end
    end

    alvio_prefix_grant #(
        .COMMIT_W (COMMIT_W)
    ) u_grant (
        .i_clean (w_clean),
        .o_grant (w_grant)
    );

    assign w_lane0  = rdData_i[WIDTH-1:0];
    assign w_detect = (r_state == RUN) & commitReady_i[0] &
                      (w_lane0 != '0);

    assign commitValid_o  = (r_state == RUN) ? w_grant : '0;
    assign busy_o         = (r_state != RUN);
    assign recoverReq_o   = r_req;
    assign recoverIdx_o   = r_idx;
    assign recoverCause_o = r_cause;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= RUN;
            r_req   <= 1'b0;
            r_idx   <= '0;
            r_cause <= '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_detect) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_idx   <= alHead_i;
                        r_cause <= w_lane0;
                    end
                end
                REQ: begin
                    if (recoverAck_i) begin
                        r_state <= DRAIN;
                        r_req   <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (flushDone_i) r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef ALVIO_STATS_EN
    logic [31:0] r_load_cnt;
    logic [31:0] r_exc_cnt;

    // Counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_load_cnt <= '0;
            r_exc_cnt  <= '0;
        end else if (w_detect) begin
            if (w_lane0[VIO_LOAD_BIT] && r_load_cnt != '1)
                r_load_cnt <= r_load_cnt + 32'd1;
            if (w_lane0[VIO_EXC_BIT] && r_exc_cnt != '1)
                r_exc_cnt <= r_exc_cnt + 32'd1;
        end
    end

    assign loadVioCnt_o = r_load_cnt;
    assign excCnt_o     = r_exc_cnt;
`endif
endmodule

// File: doc/alvio_commit_scan.md
Name: alvio_commit_scan

Overview:
Commit-side reader for the active-list violation RAM. Each cycle it drives one read address per commit lane (head+i) and takes the returned violation bits. It then grants commit to the in-order prefix of ready, clean lanes. When a violating or excepting instruction reaches lane 0, it stops commit, raises a registered recovery request to the recovery/flush logic and holds it until acknowledged, then waits for flush completion before resuming.

Parameters:
COMMIT_W, 4, number of commit lanes and RAM read ports (1..4)
DEPTH, 128, active-list entries; must equal 2**INDEX
INDEX, 7, active-list index width
WIDTH, 2, violation word width; bit0 = load violation, bit1 = exception

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
alHead_i  in  INDEX  current active-list head index
commitReady_i  in  COMMIT_W  lane i entry (head+i) has completed execution
rdAddr_o  out  COMMIT_W*INDEX  lane i read address into the violation RAM
rdData_i  in  COMMIT_W*WIDTH  lane i violation word; combinational from RAM, same cycle
commitValid_o  out  COMMIT_W  lanes granted commit this cycle
recoverReq_o  out  1  recovery request, registered
recoverIdx_o  out  INDEX  active-list index of the offending instruction
recoverCause_o  out  WIDTH  violation word of the offending instruction
recoverAck_i  in  1  recovery logic has accepted the request
flushDone_i  in  1  pipeline flush complete; sampled only in DRAIN
busy_o  out  1  state is not RUN

Behaviour:
- Reset is synchronous on the clk edge with reset_n=0. It forces state=RUN and recoverReq_o=0, and clears recoverIdx_o, recoverCause_o and the stats counters. Asserting reset in any state aborts the operation in progress; no request survives reset.
- rdAddr_o[i] = (alHead_i + i) truncated to INDEX bits, so the addresses wrap from DEPTH-1 to 0. This path is combinational in all states.
- Define clean[i] = commitReady_i[i] & (rdData_i[i]==0).
- In RUN: commitValid_o[i] = AND of clean[0..i], so the granted lanes are a contiguous prefix. In REQ and DRAIN: commitValid_o = 0.
- Detect = RUN & commitReady_i[0] & (rdData_i[0]!=0). A violation in lane k>0 only truncates the prefix at k; it is detected after head advances so the entry sits in lane 0.
- State RUN:
  - On Detect: go to REQ next cycle, latching recoverIdx_o=alHead_i and recoverCause_o=rdData_i[0].
  - recoverReq_o goes to 1 on the same edge, i.e. 1-cycle latency from detection.
- State REQ:
  - recoverReq_o, recoverIdx_o and recoverCause_o are held stable.
  - On recoverAck_i=1: recoverReq_o falls on the next edge and state goes to DRAIN.
  - An acknowledge in the same cycle that request rises is not possible, because the request is registered.
- State DRAIN: on flushDone_i=1, go to RUN next cycle. flushDone_i is ignored in RUN and REQ, including when it arrives in the same cycle as recoverAck_i.
- recoverAck_i outside REQ is ignored.
- busy_o = (state != RUN).
- Cause encoding: recoverCause_o passes rdData_i through unmodified; both bits may be set.
- Lanes with commitReady_i=0 are never granted, even if their data is clean.

Optional Feature:
ALVIO_STATS_EN
- Defined: adds outputs loadVioCnt_o[31:0] and excCnt_o[31:0]. On each Detect, loadVioCnt_o increments if cause bit0 is set, and excCnt_o increments if cause bit1 is set (both if both). Counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: no counters and no such ports; all other behaviour is identical.

Decomposition:
- Shared package alvio_pkg holds:
  - typedef scan_state_e {RUN, REQ, DRAIN};
  - constants VIO_LOAD_BIT=0 and VIO_EXC_BIT=1;
  - typedef al_idx_t logic[INDEX-1:0].
- Natural sub-module: alvio_prefix_grant, a purely combinational contiguous-prefix AND chain over COMMIT_W lanes. The FSM and latches stay in the top module.

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles with random inputs -> recoverReq_o=0, busy_o=0, recoverIdx_o=0; counters 0 when ALVIO_STATS_EN is defined.
2. Clean commit with wrap: alHead_i=126, commitReady_i=4'b1111, data all 0 -> rdAddr_o={1,0,127,126} (lane 3..0), commitValid_o=4'b1111.
3. Mid-lane violation: ready=4'b1111, rdData_i[2]=2'b01 -> commitValid_o=4'b0011, no request. Next cycle head+=2, lane0 data=01 -> commitValid_o=0, recoverReq_o=1 one cycle later with recoverIdx_o=new head and cause=01.
4. Handshake hold: hold recoverAck_i=0 for 5 cycles -> request, index and cause stable and commitValid_o=0. Pulse ack -> recoverReq_o=0 next cycle, state DRAIN. flushDone_i=1 -> RUN next cycle and commits resume.
5. Ignored inputs: flushDone_i=1 in REQ plus a stray ack in RUN -> no state change. Apply reset_n=0 while in REQ -> recoverReq_o=0 and RUN after the edge.
6. Stats (ALVIO_STATS_EN defined): three detections with causes 01, 10, 11 -> loadVioCnt_o=2, excCnt_o=2.
